// File: rtl/ins_encoder.sv
// RV32 instruction encoder: field bundle in, 32-bit word out, one output register.
// Optional immediate range checking is enabled by defining INS_ENCODER_RANGE_CHECK_EN.
module ins_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  sel,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] ins,
    output logic [31:0] addr,
    output logic        err
);

    localparam logic [2:0] SEL_I = 3'b000;
    localparam logic [2:0] SEL_S = 3'b001;
    localparam logic [2:0] SEL_B = 3'b010;
    localparam logic [2:0] SEL_U = 3'b011;
    localparam logic [2:0] SEL_J = 3'b100;
    localparam logic [2:0] SEL_R = 3'b101;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic        out_valid_q, out_valid_d;
    logic [31:0] ins_q, ins_d;
    logic [31:0] addr_q, addr_d;
    logic        err_q, err_d;

    logic [31:0] enc_ins;
    logic        enc_err;
    logic        rng_err;
    logic        accept;
    logic        out_hs;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_hs    = out_valid_q && out_ready;

    always_comb begin
        enc_ins = NOP;
        enc_err = 1'b0;
        case (sel)
            SEL_I: enc_ins = {imm[11:0], rs1, funct3, rd, opcode};
            SEL_S: enc_ins = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            SEL_B: enc_ins = {imm[12], imm[10:5], rs2, rs1, funct3,
                              imm[4:1], imm[11], opcode};
            SEL_U: enc_ins = {imm[31:12], rd, opcode};
            SEL_J: enc_ins = {imm[20], imm[10:1], imm[11], imm[19:12],
                              rd, opcode};
            SEL_R: enc_ins = {funct7, rs2, rs1, funct3, rd, opcode};
            default: begin
                enc_ins = NOP;
                enc_err = 1'b1;
            end
        endcase
    end

`ifdef INS_ENCODER_RANGE_CHECK_EN
    // An immediate fits N bits signed when all bits above N-1 copy bit N-1.
    logic fits12, fits13, fits21;
    assign fits12 = (&imm[31:11]) || !(|imm[31:11]);
    assign fits13 = (&imm[31:12]) || !(|imm[31:12]);
    assign fits21 = (&imm[31:20]) || !(|imm[31:20]);

    always_comb begin
        rng_err = 1'b0;
        case (sel)
            SEL_I:   rng_err = !fits12;
            SEL_S:   rng_err = !fits12;
            SEL_B:   rng_err = !fits13 || imm[0];
            SEL_U:   rng_err = |imm[11:0];
            SEL_J:   rng_err = !fits21 || imm[0];
            default: rng_err = 1'b0;
        endcase
    end
`else
    assign rng_err = 1'b0;
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        ins_d       = ins_q;
        err_d       = err_q;
        addr_d      = addr_q;
        if (out_hs) begin
            addr_d      = addr_q + 32'd4;
            out_valid_d = 1'b0;
        end
        if (accept) begin
            out_valid_d = 1'b1;
            ins_d       = enc_ins;
            err_d       = enc_err || rng_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            ins_q       <= 32'h0;
            err_q       <= 1'b0;
            addr_q      <= BASE_ADDR;
        end else begin
            out_valid_q <= out_valid_d;
            ins_q       <= ins_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ins       = ins_q;
    assign err       = err_q;
    assign addr      = addr_q;

endmodule

// File: doc/ins_encoder.md
INS_ENCODER -- requirements
Module: ins_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h00000000, byte address of the first encoded instruction.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  field bundle valid.
REQ-005 SHALL have port in_ready  output  1  encoder can accept bundle.
REQ-006 SHALL have port sel  input  3  format: 000 I, 001 S, 010 B, 011 U, 100 J, 101 R, 110/111 illegal.
REQ-007 SHALL have ports opcode 7, rd 5, rs1 5, rs2 5, funct3 3, funct7 7, all inputs, instruction fields.
REQ-008 SHALL have port imm  input  32  immediate value, byte units, two's complement.
REQ-009 SHALL have port out_valid  output  1  encoded instruction valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts instruction.
REQ-011 SHALL have port ins  output  32  encoded instruction word.
REQ-012 SHALL have port addr  output  32  byte address of instruction on ins.
REQ-013 SHALL have port err  output  1  encoding error flag for instruction on ins.

Function
REQ-014 SHALL accept a bundle when in_valid && in_ready at a rising edge; out_valid, ins, err update on that edge (latency 1 cycle).
REQ-015 SHALL drive in_ready = !out_valid || out_ready (single output register, combinational pass-through ready).
REQ-016 SHALL hold ins, err, addr and out_valid stable while out_valid && !out_ready.
REQ-017 SHALL clear out_valid after an output handshake with no simultaneous input acceptance; simultaneous handshake and acceptance keeps out_valid=1 with new data.
REQ-018 SHALL increment addr by 4 on every output handshake (out_valid && out_ready), wrapping modulo 2^32.
REQ-019 SHALL place opcode in ins[6:0] for all legal formats; rd in [11:7] for I/U/J/R; funct3 in [14:12] for I/S/B/R; rs1 in [19:15] for I/S/B/R; rs2 in [24:20] for S/B/R; funct7 in [31:25] for R.
REQ-020 SHALL pack immediates: I imm[11:0]->[31:20]; S imm[11:5]->[31:25], imm[4:0]->[11:7]; B imm[12]->[31], imm[10:5]->[30:25], imm[4:1]->[11:8], imm[11]->[7]; U imm[31:12]->[31:12]; J imm[20]->[31], imm[10:1]->[30:21], imm[11]->[20], imm[19:12]->[19:12].
REQ-021 SHALL ignore immediate bits not listed for a format (truncation).
REQ-022 SHALL encode illegal sel as 32'h00000013 (NOP) with err=1.

Reset
REQ-023 SHALL on rst at a rising edge set out_valid=0, ins=0, err=0, addr=BASE_ADDR, regardless of pending handshakes.
REQ-024 SHALL drive in_ready=1 in the cycle after reset and ignore in_valid during the cycle rst is high.

Configuration
REQ-025 SHALL, with macro INS_ENCODER_RANGE_CHECK_EN defined, set err=1 when imm is out of range: I/S not 12-bit sign-extended; B not 13-bit sign-extended or imm[0]=1; U imm[11:0]!=0; J not 21-bit sign-extended or imm[0]=1; R never.
REQ-026 SHALL, with range error, still emit the truncated encoding of REQ-020.
REQ-027 SHALL, without INS_ENCODER_RANGE_CHECK_EN, perform no range check; err=1 only for illegal sel.

Verification
REQ-028 SHALL test sel=000, opcode=0x13, rd=2, rs1=0, funct3=0, imm=4, out_ready=1 -> next cycle ins=0x00400113, err=0, addr=BASE_ADDR; following handshake addr=BASE_ADDR+4.
REQ-029 SHALL test sel=001, opcode=0x23, funct3=2, rs1=2, rs2=5, imm=0xFFFFFFFC -> ins=0xFE512E23, err=0.
REQ-030 SHALL test out_ready=0 for 3 cycles after one accept -> out_valid=1, ins/addr unchanged, in_ready=0; out_ready=1 then -> handshake, addr+4.
REQ-031 SHALL test sel=000, imm=2048 -> ins[31:20]=0x800; err=1 with INS_ENCODER_RANGE_CHECK_EN, err=0 without.
REQ-032 SHALL test sel=111 -> ins=0x00000013, err=1 in both builds.
REQ-033 SHALL test rst asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, addr=BASE_ADDR, in_ready=1.
